// File: rtl/render_scheduler.sv
// Per-frame render sequencer: optional screen clear, then each client's draw in fixed order.
// Only the active client's pixel stream is forwarded to the single VGA plot port.
module render_scheduler #(
  parameter int unsigned NUM_CLIENTS = 3,
  parameter int unsigned SCREEN_X    = 640,
  parameter int unsigned SCREEN_Y    = 480,
  parameter int unsigned WAIT_MAX    = 4095,
  localparam int unsigned XW         = $clog2(SCREEN_X) + 1,
  localparam int unsigned YW         = $clog2(SCREEN_Y) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic                      score_event,
  output logic [NUM_CLIENTS-1:0]    cl_start,
  input  logic [NUM_CLIENTS-1:0]    cl_done,
  input  logic [NUM_CLIENTS*XW-1:0] cl_x,
  input  logic [NUM_CLIENTS*YW-1:0] cl_y,
  input  logic [NUM_CLIENTS*3-1:0]  cl_col,
  output logic                      blk_start,
  input  logic                      blk_done,
  input  logic [XW-1:0]             blk_x,
  input  logic [YW-1:0]             blk_y,
  output logic [XW-1:0]             vga_x,
  output logic [YW-1:0]             vga_y,
  output logic [2:0]                vga_col,
  output logic                      vga_plot,
  output logic                      busy,
  output logic [7:0]                overrun_cnt,
  output logic                      timeout_flag
);

  localparam int unsigned IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned CW = $clog2(WAIT_MAX + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_BLK_START = 3'd1;
  localparam logic [2:0] S_BLK_WAIT  = 3'd2;
  localparam logic [2:0] S_CL_START  = 3'd3;
  localparam logic [2:0] S_CL_WAIT   = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pend_blk_q, pend_blk_d;
  logic                   timeout_q, timeout_d;
  logic [7:0]             overrun_q, overrun_d;
  logic                   blk_start_q, blk_start_d;
  logic [NUM_CLIENTS-1:0] cl_start_q, cl_start_d;
  logic [XW-1:0]          vga_x_q, vga_x_d;
  logic [YW-1:0]          vga_y_q, vga_y_d;
  logic [2:0]             vga_col_q, vga_col_d;
  logic                   vga_plot_q, vga_plot_d;

  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;
  logic [2:0]    sel_col;
  logic          sel_done;
  logic          cnt_max;

  // Select the pixel stream and done line of the client currently being served.
  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_col  = '0;
    sel_done = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_x    = cl_x[i*XW +: XW];
        sel_y    = cl_y[i*YW +: YW];
        sel_col  = cl_col[i*3 +: 3];
        sel_done = cl_done[i];
      end
    end
  end

  assign cnt_max = (cnt_q == CW'(WAIT_MAX));

  // Next-state, plot path and bookkeeping.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pend_blk_d = pend_blk_q;
    timeout_d  = timeout_q;
    overrun_d  = overrun_q;
    vga_x_d    = '0;
    vga_y_d    = '0;
    vga_col_d  = 3'b000;
    vga_plot_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          idx_d   = '0;
          state_d = pend_blk_q ? S_BLK_START : S_CL_START;
        end
      end
      S_BLK_START: begin
        state_d    = S_BLK_WAIT;
        cnt_d      = '0;
        pend_blk_d = 1'b0;
      end
      S_BLK_WAIT: begin
        if (blk_done || cnt_max) begin
          state_d = S_CL_START;
          idx_d   = '0;
          if (!blk_done) timeout_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + CW'(1);
          vga_x_d    = blk_x;
          vga_y_d    = blk_y;
          vga_plot_d = 1'b1;
        end
      end
      S_CL_START: begin
        state_d = S_CL_WAIT;
        cnt_d   = '0;
      end
      S_CL_WAIT: begin
        if (sel_done || cnt_max) begin
          if (!sel_done) timeout_d = 1'b1;
          if (idx_q < IW'(NUM_CLIENTS - 1)) begin
            idx_d   = idx_q + IW'(1);
            state_d = S_CL_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d      = cnt_q + CW'(1);
          vga_x_d    = sel_x;
          vga_y_d    = sel_y;
          vga_col_d  = sel_col;
          vga_plot_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A score event always wins, even against the clear that is starting now.
    if (score_event) pend_blk_d = 1'b1;

    if (frame_tick && (state_q != S_IDLE) && (overrun_q != 8'hFF))
      overrun_d = overrun_q + 8'd1;

    blk_start_d = (state_d == S_BLK_START);
    cl_start_d  = (state_d == S_CL_START) ? (NUM_CLIENTS'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      pend_blk_q  <= 1'b1;
      timeout_q   <= 1'b0;
      overrun_q   <= '0;
      blk_start_q <= 1'b0;
      cl_start_q  <= '0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_col_q   <= '0;
      vga_plot_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pend_blk_q  <= pend_blk_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      blk_start_q <= blk_start_d;
      cl_start_q  <= cl_start_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_col_q   <= vga_col_d;
      vga_plot_q  <= vga_plot_d;
    end
  end

  assign blk_start    = blk_start_q;
  assign cl_start     = cl_start_q;
  assign vga_x        = vga_x_q;
  assign vga_y        = vga_y_q;
  assign vga_col      = vga_col_q;
  assign vga_plot     = vga_plot_q;
  assign busy         = (state_q != S_IDLE);
  assign overrun_cnt  = overrun_q;
  assign timeout_flag = timeout_q;

endmodule
